seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the team's BCD-to-7-segment decoder: watches a multiplexed, active-high 7-segment display bus (segment lines plus one-hot digit strobes) and reconstructs the displayed BCD digits.
- Each strobe window is filtered for stability, the pattern is decoded back to BCD, and a complete multi-digit frame is published with a one-cycle valid pulse.
- Used as a display-bus monitor and self-check block beside the display driver.

---
 rtl/seg7_scan_decoder.sv | 126 ++++++++++++
 tb/tb_seg7_scan_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Display-bus monitor: samples a multiplexed active-high 7-segment bus, filters each
// strobe window for stability, decodes digits back to BCD and publishes whole frames.
module seg7_scan_decoder #(
  parameter int unsigned NDIG   = 4,
  parameter int unsigned STABLE = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg,
  input  logic [NDIG-1:0]     dig,
  output logic [4*NDIG-1:0]   bcd,
  output logic [NDIG-1:0]     blank,
  output logic [NDIG-1:0]     bad,
  output logic                frame_valid
);

  localparam int unsigned CW = 4;
  localparam int unsigned BW = 4 * NDIG;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(STABLE - 2);

  logic [6:0]      s_seg;
  logic [NDIG-1:0] s_dig;
  logic [CW-1:0]   cnt;
  logic [NDIG-1:0] seen;
  logic [BW-1:0]   w_bcd;
  logic [NDIG-1:0] w_blank;
  logic [NDIG-1:0] w_bad;

  logic [3:0]      dec_val_c;
  logic            dec_blank_c;
  logic            dec_bad_c;
  logic            same_c;
  logic            onehot_c;
  logic            capture_c;
  logic            frame_done_c;
  logic [NDIG-1:0] seen_c;
  logic [BW-1:0]   w_bcd_c;
  logic [NDIG-1:0] w_blank_c;
  logic [NDIG-1:0] w_bad_c;

  // Reverse segment decode of the sampled pattern
  always_comb begin
    dec_val_c   = 4'd0;
    dec_blank_c = 1'b0;
    dec_bad_c   = 1'b0;
    case (s_seg)
      7'b1111110: dec_val_c = 4'd0;
      7'b0110000: dec_val_c = 4'd1;
      7'b1101101: dec_val_c = 4'd2;
      7'b1111001: dec_val_c = 4'd3;
      7'b0110011: dec_val_c = 4'd4;
      7'b1011011: dec_val_c = 4'd5;
      7'b1011111: dec_val_c = 4'd6;
      7'b1110000: dec_val_c = 4'd7;
      7'b1111111: dec_val_c = 4'd8;
      7'b1111011: dec_val_c = 4'd9;
      7'b0000000: dec_blank_c = 1'b1;
      default:    dec_bad_c   = 1'b1;
    endcase
  end

  // Incoming pair equal to the held sample means the window keeps counting this edge,
  // so the capture lands STABLE-1 edges after the pair is first sampled.
  always_comb begin
    same_c       = (seg == s_seg) && (dig == s_dig);
    onehot_c     = (s_dig != '0) && ((s_dig & (s_dig - NDIG'(1))) == '0);
    capture_c    = same_c && (cnt == CNT_PRE) && onehot_c;
    seen_c       = seen | s_dig;
    frame_done_c = capture_c && (seen_c == '1);
  end

  // Working slots with the current capture merged in
  always_comb begin
    w_bcd_c   = w_bcd;
    w_blank_c = w_blank;
    w_bad_c   = w_bad;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (s_dig[i]) begin
        w_bcd_c[4*i +: 4] = dec_val_c;
        w_blank_c[i]      = dec_blank_c;
        w_bad_c[i]        = dec_bad_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg       <= '0;
      s_dig       <= '0;
      cnt         <= '0;
      seen        <= '0;
      w_bcd       <= '0;
      w_blank     <= '0;
      w_bad       <= '0;
      bcd         <= '0;
      blank       <= '0;
      bad         <= '0;
      frame_valid <= 1'b0;
    end else begin
      s_seg       <= seg;
      s_dig       <= dig;
      frame_valid <= 1'b0;
      if (!same_c) begin
        cnt <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + CW'(1);
      end
      if (capture_c) begin
        w_bcd   <= w_bcd_c;
        w_blank <= w_blank_c;
        w_bad   <= w_bad_c;
        if (frame_done_c) begin
          bcd         <= w_bcd_c;
          blank       <= w_blank_c;
          bad         <= w_bad_c;
          frame_valid <= 1'b1;
          seen        <= '0;
        end else begin
          seen <= seen_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomized scoreboard bench for seg7_scan_decoder against a run-length display model.
module tb_seg7_scan_decoder;

  localparam int NDIG   = 4;
  localparam int STABLE = 3;

  logic                clk;
  logic                rst_n;
  logic [6:0]          seg;
  logic [NDIG-1:0]     dig;
  logic [4*NDIG-1:0]   bcd;
  logic [NDIG-1:0]     blank;
  logic [NDIG-1:0]     bad;
  logic                frame_valid;

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dig(dig),
    .bcd(bcd), .blank(blank), .bad(bad), .frame_valid(frame_valid)
  );

  typedef struct {
    logic [4*NDIG-1:0] bcd;
    logic [NDIG-1:0]   blank;
    logic [NDIG-1:0]   bad;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  logic [4*NDIG-1:0] last_bcd = '0;
  logic [NDIG-1:0]   last_blank = '0;
  logic [NDIG-1:0]   last_bad = '0;

  // Model state: current held bus value, its run and the digits gathered so far
  logic [6:0]      cur_seg;
  logic [NDIG-1:0] cur_dig;
  int              run_start, run_len;
  int              m_val [NDIG];
  bit              m_blank [NDIG];
  bit              m_bad [NDIG];
  bit              m_seen [NDIG];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      default: return 7'b1111011;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && frame_valid === 1'b1) begin
      exp_t e;
      pulses++;
      last_bcd   = bcd;
      last_blank = blank;
      last_bad   = bad;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame actual=%0h required=none (t=%0t)", bcd, $time);
      end else begin
        e = sb.pop_front();
        check("frame_bcd", 64'(bcd), 64'(e.bcd));
        check("frame_blank", 64'(blank), 64'(e.blank));
        check("frame_bad", 64'(bad), 64'(e.bad));
        check("frame_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < NDIG; i++) begin
      m_val[i] = 0; m_blank[i] = 0; m_bad[i] = 0; m_seen[i] = 0;
    end
  endtask

  // Drive one bus value for n cycles; the model captures when a one-hot run reaches STABLE
  task automatic step(input logic [6:0] sg, input logic [NDIG-1:0] dg, input int n);
    int old;
    int all;
    exp_t e;
    seg = sg;
    dig = dg;
    if (sg !== cur_seg || dg !== cur_dig) begin
      cur_seg = sg; cur_dig = dg; run_start = cyc; run_len = 0;
    end
    old = run_len;
    run_len += n;
    if (old < STABLE && run_len >= STABLE && $countones(dg) == 1) begin
      for (int i = 0; i < NDIG; i++) begin
        if (dg[i]) begin
          m_val[i] = 0;
          m_blank[i] = (sg == 7'b0000000);
          m_bad[i] = !m_blank[i];
          for (int d = 0; d < 10; d++) begin
            if (seg_of(d) == sg) begin
              m_val[i] = d;
              m_bad[i] = 0;
            end
          end
          m_seen[i] = 1;
        end
      end
      all = 1;
      for (int i = 0; i < NDIG; i++) if (!m_seen[i]) all = 0;
      if (all == 1) begin
        for (int i = 0; i < NDIG; i++) begin
          e.bcd[4*i +: 4] = 4'(m_val[i]);
          e.blank[i] = m_blank[i];
          e.bad[i] = m_bad[i];
          m_seen[i] = 0;
        end
        e.cyc = run_start + STABLE;
        sb.push_back(e);
      end
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      seg = 7'($urandom);
      dig = NDIG'($urandom);
      @(posedge clk);
      #1;
      check("rst_bcd", 64'(bcd), 64'd0);
      check("rst_blank", 64'(blank), 64'd0);
      check("rst_bad", 64'(bad), 64'd0);
      check("rst_valid", 64'(frame_valid), 64'd0);
    end
    seg = '0;
    dig = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur_seg = '0; cur_dig = '0; run_start = cyc; run_len = 0;
    model_clear();
  endtask

  task automatic scan(input int d0, input int d1, input int d2, input int d3, input int n);
    step(seg_of(d0), 4'b0001, n);
    step(seg_of(d1), 4'b0010, n);
    step(seg_of(d2), 4'b0100, n);
    step(seg_of(d3), 4'b1000, n);
  endtask

  initial begin
    int p;
    logic [NDIG-1:0] rd;
    rst_n = 1'b0;
    seg = '0;
    dig = '0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset(8);
    step(7'd0, 4'b0000, 20);
    check("idle_no_frame", 64'(pulses), 64'd0);

    // Basic scan: digits 0..3 show 4,3,2,1
    scan(4, 3, 2, 1, 4);
    step(7'd0, 4'b0000, 6);
    check("scan_pulses", 64'(pulses), 64'd1);
    check("scan_bcd_1234", 64'(last_bcd), 64'h1234);

    // Windows shorter than STABLE never capture; exactly STABLE does
    p = pulses;
    scan(5, 6, 7, 8, 2);
    step(7'd0, 4'b0000, 6);
    check("short_no_frame", 64'(pulses), 64'(p));
    scan(5, 6, 7, 8, 3);
    step(7'd0, 4'b0000, 6);
    check("min_window_frame", 64'(pulses), 64'(p + 1));
    check("min_window_bcd", 64'(last_bcd), 64'h8765);

    // Blank and illegal patterns
    step(seg_of(5), 4'b0001, 4);
    step(7'b1001001, 4'b0010, 4);
    step(7'b0000000, 4'b0100, 4);
    step(seg_of(9), 4'b1000, 4);
    step(7'd0, 4'b0000, 6);
    check("blank_mask", 64'(last_blank), 64'h4);
    check("bad_mask", 64'(last_bad), 64'h2);
    check("blank_bad_bcd", 64'(last_bcd), 64'h9005);

    // Multi-hot strobe ignored; recapture of digit 0 overwrites its slot
    p = pulses;
    step(seg_of(3), 4'b0001, 4);
    step(seg_of(5), 4'b0011, 10);
    step(seg_of(2), 4'b0010, 4);
    step(seg_of(7), 4'b0001, 4);
    step(seg_of(4), 4'b0100, 4);
    check("partial_no_frame", 64'(pulses), 64'(p));
    step(seg_of(8), 4'b1000, 4);
    step(7'd0, 4'b0000, 6);
    check("recapture_frames", 64'(pulses), 64'(p + 1));
    check("recapture_nibble0", 64'(last_bcd[3:0]), 64'd7);

    // Reset mid-frame discards the three gathered digits
    p = pulses;
    step(seg_of(1), 4'b0001, 4);
    step(seg_of(2), 4'b0010, 4);
    step(seg_of(3), 4'b0100, 4);
    do_reset(3);
    step(seg_of(6), 4'b1000, 5);
    step(7'd0, 4'b0000, 8);
    check("post_reset_no_frame", 64'(pulses), 64'(p));
    scan(0, 9, 1, 6, 4);
    step(7'd0, 4'b0000, 6);
    check("post_reset_frame", 64'(pulses), 64'(p + 1));
    check("post_reset_bcd", 64'(last_bcd), 64'h6190);

    // Randomized scan traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        rd = NDIG'($urandom);
      end else begin
        rd = '0;
        rd[$urandom_range(0, NDIG - 1)] = 1'b1;
      end
      step(($urandom_range(0, 9) == 0) ? 7'($urandom) : seg_of(int'($urandom_range(0, 9))),
           rd, int'($urandom_range(1, 6)));
    end
    step(7'd0, 4'b0000, 10);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
